// File: rtl/pid_frame_ctrl.sv
// PID frame controller: turns each sensor sample into a start/done handshake with the PID engine and a clamped actuator command.
// Optional: define PID_FRAME_SLEW_EN to limit each command update to +/-SLEW_MAX.
module pid_frame_ctrl #(
  parameter int unsigned OUT_W       = 12,
  parameter int unsigned OFFSET      = 2048,
  parameter int unsigned SHIFT       = 4,
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned SLEW_MAX    = 64
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             en,
  input  logic             sample_valid,
  input  logic [31:0]      setpoint,
  input  logic [31:0]      measurement,
  input  logic [31:0]      pid_out,
  input  logic             pid_done,
  output logic             start_calc,
  output logic [31:0]      error,
  output logic [31:0]      delta_t,
  output logic [OUT_W-1:0] cmd,
  output logic             cmd_valid,
  output logic             busy,
  output logic             timeout,
  output logic [7:0]       overrun_cnt
);

  localparam int unsigned TMR_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned CW    = 33;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0]    CMD_MAX  = CW'((64'(1) << OUT_W) - 64'(1));
  localparam logic [CW-1:0]    OFF      = CW'(OFFSET);

  // Elaboration-time guard on parameter combinations that would break the command math.
  if ((64'(OFFSET) >= (64'(1) << OUT_W)) || (SLEW_MAX == 0)) begin : g_bad_params
    $error("pid_frame_ctrl: OFFSET must be below 2**OUT_W and SLEW_MAX nonzero");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_APPLY  = 2'd3
  } state_t;

  state_t           r_state;
  logic             r_start_calc;
  logic [31:0]      r_error;
  logic [31:0]      r_delta_t;
  logic [OUT_W-1:0] r_cmd;
  logic             r_cmd_valid;
  logic             r_busy;
  logic             r_timeout;
  logic [7:0]       r_overrun;
  logic [31:0]      r_period;
  logic [TMR_W-1:0] r_timer;
  logic [31:0]      r_pid;

  // Sign-magnitude error = setpoint - measurement, saturating, with -0 folded to +0.
  logic        w_sp_s;
  logic        w_ms_s;
  logic [30:0] w_sp_m;
  logic [30:0] w_ms_m;
  logic [31:0] w_sum;
  logic [30:0] w_err_mag;
  logic        w_err_sign;
  logic [31:0] w_err;

  assign w_sp_s = setpoint[31];
  assign w_sp_m = setpoint[30:0];
  assign w_ms_s = measurement[31];
  assign w_ms_m = measurement[30:0];

  always_comb begin
    w_sum      = {1'b0, w_sp_m} + {1'b0, w_ms_m};
    w_err_mag  = '0;
    w_err_sign = 1'b0;
    if (w_sp_s != w_ms_s) begin
      w_err_mag  = w_sum[31] ? 31'h7FFF_FFFF : w_sum[30:0];
      w_err_sign = w_sp_s;
    end else if (w_sp_m >= w_ms_m) begin
      w_err_mag  = w_sp_m - w_ms_m;
      w_err_sign = w_sp_s;
    end else begin
      w_err_mag  = w_ms_m - w_sp_m;
      w_err_sign = ~w_sp_s;
    end
    if (w_err_mag == '0) begin
      w_err_sign = 1'b0;
    end
    w_err = {w_err_sign, w_err_mag};
  end

  // Command from the captured PID result: offset, clamp to the output range, optional slew limit.
  logic [CW-1:0] w_shifted;
  logic [CW-1:0] w_cmd_clamp;
  logic [CW-1:0] w_cmd_next;
`ifdef PID_FRAME_SLEW_EN
  localparam logic [CW-1:0] SLEW = CW'(SLEW_MAX);
  logic [CW-1:0] w_prev;
  assign w_prev = CW'(r_cmd);
`endif

  always_comb begin
    w_shifted   = CW'(r_pid[30:0] >> SHIFT);
    w_cmd_clamp = '0;
    if (r_pid[31]) begin
      w_cmd_clamp = (w_shifted > OFF) ? '0 : (OFF - w_shifted);
    end else begin
      w_cmd_clamp = ((OFF + w_shifted) > CMD_MAX) ? CMD_MAX : (OFF + w_shifted);
    end
`ifdef PID_FRAME_SLEW_EN
    if (w_cmd_clamp > (w_prev + SLEW)) begin
      w_cmd_next = w_prev + SLEW;
    end else if ((w_cmd_clamp + SLEW) < w_prev) begin
      w_cmd_next = w_prev - SLEW;
    end else begin
      w_cmd_next = w_cmd_clamp;
    end
`else
    w_cmd_next = w_cmd_clamp;
`endif
  end

  // Frame sequencer; everything freezes while en is low.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state      <= S_IDLE;
      r_start_calc <= 1'b0;
      r_error      <= '0;
      r_delta_t    <= '0;
      r_cmd        <= OUT_W'(OFFSET);
      r_cmd_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_timeout    <= 1'b0;
      r_overrun    <= '0;
      r_period     <= '0;
      r_timer      <= '0;
      r_pid        <= '0;
    end else if (en) begin
      r_start_calc <= 1'b0;
      r_cmd_valid  <= 1'b0;
      if (r_period != 32'hFFFF_FFFF) begin
        r_period <= r_period + 32'd1;
      end
      if (sample_valid && (r_state != S_IDLE) && (r_overrun != 8'hFF)) begin
        r_overrun <= r_overrun + 8'd1;
      end
      case (r_state)
        S_IDLE: begin
          if (sample_valid) begin
            r_error      <= w_err;
            r_delta_t    <= r_period;
            r_period     <= 32'd1;
            r_start_calc <= 1'b1;
            r_busy       <= 1'b1;
            r_state      <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          r_timer <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (pid_done) begin
            r_pid   <= pid_out;
            r_state <= S_APPLY;
          end else if (r_timer == TMR_LAST) begin
            r_timeout <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= S_IDLE;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        S_APPLY: begin
          r_cmd       <= OUT_W'(w_cmd_next);
          r_cmd_valid <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Strobes are suppressed while disabled and resume once en returns.
  assign start_calc  = r_start_calc & en;
  assign cmd_valid   = r_cmd_valid & en;
  assign error       = r_error;
  assign delta_t     = r_delta_t;
  assign cmd         = r_cmd;
  assign busy        = r_busy;
  assign timeout     = r_timeout;
  assign overrun_cnt = r_overrun;

endmodule
